hazard_scoreboard: RTL and testbench

- Parametrised successor to the pipeline forwarding unit. Tracks in-flight register writers in E/M/W with per-entry Tnew countdowns.
- Per decode source it emits forwarding selects and a global stall from a Tnew/Tuse comparison.
- Adds a multi-cycle MDU (mult/div) busy counter that stalls HI/LO consumers.
- Sits between decode and the datapath muxes, and replaces fixed per-kind forwarding tables.

---
 rtl/hazard_scoreboard.sv | 114 +++++++++++
 tb/tb_hazard_scoreboard.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: Tnew/Tuse hazard tracker with E/M/W writer entries, forwarding selects and MDU busy stall; SCB_STALL_CNT_EN adds a saturating stall_cycles counter
module hazard_scoreboard #(
  parameter int NSRC     = 2,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [NSRC*5-1:0] d_src,
  input  logic [NSRC*2-1:0] d_tuse,
  input  logic [4:0]        d_dst,
  input  logic [1:0]        d_tnew,
  input  logic              d_mdu_start,
  input  logic              d_mdu_div,
  input  logic              d_uses_hilo,
  input  logic              flush,
  output logic              stall,
  output logic [NSRC*2-1:0] fwd_sel,
  output logic              mdu_busy
`ifdef SCB_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);
  typedef struct packed {
    logic       v;
    logic [4:0] dst;
    logic [1:0] tnew;
  } ent_t;

  localparam logic [7:0] MULT_C = 8'(MULT_LAT);
  localparam logic [7:0] DIV_C  = 8'(DIV_LAT);

  ent_t e_q, e_d, m_q, m_d, w_q, w_d;
  logic [7:0] cnt_q, cnt_d;
  logic [NSRC-1:0] haz;

  function automatic ent_t age(input ent_t x);
    return '{v: x.v, dst: x.dst, tnew: (x.tnew == 2'd0) ? 2'd0 : x.tnew - 2'd1};
  endfunction

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    logic [4:0] s;
    logic [1:0] tu, tn, sel;
    logic he, hm, hw;
    assign s  = d_src[5*i +: 5];
    assign tu = d_tuse[2*i +: 2];
    assign he = e_q.v && e_q.dst == s;
    assign hm = m_q.v && m_q.dst == s;
    assign hw = w_q.v && w_q.dst == s;
    assign sel = (s == '0) ? 2'd0 : he ? 2'd1 : hm ? 2'd2 : hw ? 2'd3 : 2'd0;
    assign tn  = he ? e_q.tnew : hm ? m_q.tnew : w_q.tnew;
    assign haz[i] = d_valid && sel != 2'd0 && tn > tu;
    assign fwd_sel[2*i +: 2] = sel;
  end

  assign mdu_busy = cnt_q != '0;
  assign stall    = d_valid && (|haz || (d_uses_hilo && mdu_busy));

  // advance writers down the pipe, ageing tnew; flush drops everything in flight
  always_comb begin
    e_d = e_q;
    m_d = m_q;
    w_d = w_q;
    if (flush) begin
      e_d.v = 1'b0;
      m_d.v = 1'b0;
      w_d.v = 1'b0;
    end else begin
      w_d = age(m_q);
      m_d = age(e_q);
      e_d = stall ? '0 : '{v: d_valid && d_dst != '0, dst: d_dst, tnew: d_tnew};
    end
  end

  // MDU busy counter: load on an issued mult/div, otherwise count down (also while stalled)
  always_comb begin
    cnt_d = (d_valid && d_mdu_start && !stall && !flush) ? (d_mdu_div ? DIV_C : MULT_C)
          : mdu_busy ? cnt_q - 8'd1 : cnt_q;
  end

  // scoreboard state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= m_d;
      w_q   <= w_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef SCB_STALL_CNT_EN
  logic [31:0] sc_q, sc_d;

  // saturating count of stalled decode cycles
  always_comb begin
    sc_d = (stall && sc_q != 32'hFFFF_FFFF) ? sc_q + 32'd1 : sc_q;
  end

  // stall counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sc_q <= '0;
    else sc_q <= sc_d;
  end

  assign stall_cycles = sc_q;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;
  logic clk = 1'b0, reset = 1'b1;
  logic d_valid = 1'b0, flush = 1'b0, d_mdu_start = 1'b0, d_mdu_div = 1'b0, d_uses_hilo = 1'b0;
  logic [9:0] d_src = '0;
  logic [3:0] d_tuse = '0;
  logic [4:0] d_dst = '0;
  logic [1:0] d_tnew = '0;
  logic stall, mdu_busy;
  logic [3:0] fwd_sel;
`ifdef SCB_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif
  int n_cmp = 0, n_err = 0, exp_sc = 0, n;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NSRC(2), .MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_src(d_src), .d_tuse(d_tuse),
    .d_dst(d_dst), .d_tnew(d_tnew), .d_mdu_start(d_mdu_start), .d_mdu_div(d_mdu_div),
    .d_uses_hilo(d_uses_hilo), .flush(flush), .stall(stall), .fwd_sel(fwd_sel),
    .mdu_busy(mdu_busy)
`ifdef SCB_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stall(input string tag, input logic exp);
    if (exp) exp_sc++;
    chk(tag, 32'(stall), 32'(exp));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [4:0] s0, input logic [1:0] u0,
                     input logic [4:0] s1, input logic [1:0] u1, input logic [4:0] dst,
                     input logic [1:0] tn, input logic ms, input logic md, input logic hl);
    d_valid = v; d_src = {s1, s0}; d_tuse = {u1, u0}; d_dst = dst; d_tnew = tn;
    d_mdu_start = ms; d_mdu_div = md; d_uses_hilo = hl;
    #1;
  endtask

  initial begin
    #2;
    chk_stall("rst_stall", 1'b0);
    chk("rst_fwd", 32'(fwd_sel), 32'h0);
    chk("rst_busy", 32'(mdu_busy), 32'h0);
    tick; reset = 1'b0;
    drv(0, 0,0, 0,0, 0,0, 0,0,0);
    chk_stall("idle_stall", 1'b0);
    chk("idle_fwd", 32'(fwd_sel), 32'h0);
    chk("idle_busy", 32'(mdu_busy), 32'h0);
    tick;
    // ALU producer then branch reading it at D
    drv(1, 1,1, 2,1, 3,1, 0,0,0); chk_stall("alu_issue", 1'b0); tick;
    drv(1, 3,0, 0,0, 0,0, 0,0,0); chk_stall("alu_use_stall", 1'b1);
    chk("alu_use_fwd", 32'(fwd_sel), 32'h1); tick;
    chk_stall("alu_after_stall", 1'b0); chk("alu_after_fwd", 32'(fwd_sel), 32'h2); tick;
    // load-use, then W forwarding and E forwarding with enough slack
    drv(1, 0,0, 0,0, 5,2, 0,0,0); chk_stall("lw_issue", 1'b0); tick;
    drv(1, 5,1, 3,1, 6,1, 0,0,0); chk_stall("lu_stall", 1'b1);
    chk("lu_fwd_stalled", 32'(fwd_sel), 32'h1); tick;
    chk_stall("lu_after_stall", 1'b0); chk("lu_after_fwd", 32'(fwd_sel), 32'h2); tick;
    drv(1, 5,0, 6,1, 0,0, 0,0,0); chk_stall("w_e_stall", 1'b0);
    chk("w_e_fwd", 32'(fwd_sel), 32'h7); tick;
    // store data operand right behind a load
    drv(1, 0,0, 0,0, 8,2, 0,0,0); chk_stall("lw2_issue", 1'b0); tick;
    drv(1, 0,1, 8,2, 0,0, 0,0,0); chk_stall("sw_stall", 1'b0);
    chk("sw_fwd", 32'(fwd_sel), 32'h4); tick;
    // two writers of $7: youngest (M) must win over W
    drv(1, 0,0, 0,0, 7,1, 0,0,0); tick;
    drv(1, 0,0, 0,0, 7,1, 0,0,0); tick;
    drv(0, 7,0, 0,0, 7,1, 0,0,0); chk_stall("novalid_stall", 1'b0);
    chk("novalid_fwd", 32'(fwd_sel), 32'h1); tick;
    drv(1, 7,0, 0,0, 0,1, 0,0,0); chk_stall("prio_stall", 1'b0);
    chk("prio_fwd", 32'(fwd_sel), 32'h2); tick;
    drv(1, 0,0, 0,0, 0,1, 0,0,0); chk_stall("zero_stall", 1'b0);
    chk("zero_fwd", 32'(fwd_sel), 32'h0); tick;
    // div then mflo
    drv(1, 0,0, 0,0, 0,0, 1,1,1); chk_stall("div_issue", 1'b0);
    chk("div_issue_busy", 32'(mdu_busy), 32'h0); tick;
    drv(1, 0,0, 0,0, 2,1, 0,0,1); chk("div_busy", 32'(mdu_busy), 32'h1);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (!stall) break;
      n++; tick; #1;
    end
    exp_sc += n;
    chk("div_stall_len", 32'(n), 32'd10);
    chk("div_done_busy", 32'(mdu_busy), 32'h0); tick;
    // mult then mflo
    drv(1, 0,0, 0,0, 0,0, 1,0,1); chk_stall("mult_issue", 1'b0); tick;
    drv(1, 0,0, 0,0, 2,1, 0,0,1);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (!stall) break;
      n++; tick; #1;
    end
    exp_sc += n;
    chk("mult_stall_len", 32'(n), 32'd5); tick;
    // unrelated ALU op right after div is not held up
    drv(1, 0,0, 0,0, 0,0, 1,1,1); tick;
    drv(1, 1,1, 2,1, 9,1, 0,0,0); chk_stall("div_alu_stall", 1'b0);
    chk("div_alu_busy", 32'(mdu_busy), 32'h1); tick;
    // flush with a dependent reader stalled in D
    drv(1, 0,0, 0,0, 4,2, 0,0,0); chk_stall("fl_lw_issue", 1'b0); tick;
    flush = 1'b1;
    drv(1, 4,0, 0,0, 0,0, 0,0,0); chk_stall("fl_pre_stall", 1'b1);
    chk("fl_pre_fwd", 32'(fwd_sel), 32'h1); tick;
    flush = 1'b0;
    drv(1, 4,0, 0,0, 0,0, 0,0,0); chk_stall("fl_post_stall", 1'b0);
    chk("fl_post_fwd", 32'(fwd_sel), 32'h0);
`ifdef SCB_STALL_CNT_EN
    chk("stall_cycles", stall_cycles, 32'(exp_sc));
`endif
    tick;
    // asynchronous reset in the middle of a divide
    drv(1, 0,0, 0,0, 0,0, 1,1,1); tick;
    drv(0, 0,0, 0,0, 0,0, 0,0,0); chk("ar_busy_before", 32'(mdu_busy), 32'h1);
    #2 reset = 1'b1;
    #1 chk("ar_busy_now", 32'(mdu_busy), 32'h0);
    drv(1, 0,0, 0,0, 0,0, 0,0,1); chk_stall("ar_hilo_stall", 1'b0);
`ifdef SCB_STALL_CNT_EN
    chk("ar_stall_cycles", stall_cycles, 32'h0);
`endif
    tick; reset = 1'b0;
    drv(0, 0,0, 0,0, 0,0, 0,0,0); chk("ar_busy_after", 32'(mdu_busy), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
